// File: rtl/z80_io_tx_fifo.sv
// Z80 I/O-space TX FIFO: OUT to BASE_ADDR queues a byte, BASE_ADDR+1 gives STATUS/CTRL,
// and a valid/ready stream drains the queue to a downstream consumer.
module z80_io_tx_fifo #(
  parameter logic [7:0] BASE_ADDR = 8'hBB,
  parameter int         DEPTH     = 16
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [7:0] address,
  input  logic [7:0] cpu_dout,
  input  logic       rd_n,
  input  logic       wr_n,
  input  logic       iorq_n,
  input  logic       m1_n,
  output logic [7:0] rd_data,
  output logic       rd_sel,
  output logic [7:0] out_data,
  output logic       out_valid,
  input  logic       out_ready
);

  localparam int          AW        = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [7:0]  CTRL_ADDR = BASE_ADDR + 8'd1;
  localparam logic [AW:0] DEPTH_C   = (AW+1)'(DEPTH);

  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          ovf_q, ovf_d;
  logic          wr_prev_q, rd_prev_q;
  logic [7:0]    rd_data_q, rd_data_d;

  logic io_wr, io_rd, wr_edge, rd_edge, hit_data, hit_ctrl;
  logic empty, full, pop, push_req, push_ok, flush, ovf_new, status_rd;
  logic [4:0] count5;

  // Bus decode: interrupt-acknowledge cycles (M1 low) never count as I/O.
  assign io_wr    = !iorq_n && !wr_n && m1_n;
  assign io_rd    = !iorq_n && !rd_n && m1_n;
  assign wr_edge  = io_wr && !wr_prev_q;
  assign rd_edge  = io_rd && !rd_prev_q;
  assign hit_data = (address == BASE_ADDR);
  assign hit_ctrl = (address == CTRL_ADDR);

  assign empty     = (count_q == '0);
  assign full      = (count_q == DEPTH_C);
  assign pop       = !empty && out_ready;
  assign push_req  = wr_edge && hit_data;
  assign push_ok   = push_req && (!full || pop);
  assign ovf_new   = push_req && !push_ok;
  assign flush     = wr_edge && hit_ctrl && cpu_dout[0];
  assign status_rd = rd_edge && hit_ctrl;
  assign count5    = 5'(count_q);

  assign rd_sel    = io_rd && (hit_data || hit_ctrl);
  assign rd_data   = rd_data_q;
  assign out_valid = !empty;
  assign out_data  = empty ? 8'h00 : mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    ovf_d     = ovf_q;
    rd_data_d = rd_data_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
      ovf_d    = 1'b0;
    end else begin
      if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop)     rd_ptr_d = rd_ptr_q + AW'(1);
      if (push_ok && !pop)      count_d = count_q + (AW+1)'(1);
      else if (pop && !push_ok) count_d = count_q - (AW+1)'(1);
      // A fresh overflow in the same cycle as the STATUS read must not be lost.
      if (ovf_new)        ovf_d = 1'b1;
      else if (status_rd) ovf_d = 1'b0;
    end
    if (status_rd) rd_data_d = {count5, ovf_q, full, empty};
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      ovf_q     <= 1'b0;
      wr_prev_q <= 1'b0;
      rd_prev_q <= 1'b0;
      rd_data_q <= 8'h00;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      ovf_q     <= ovf_d;
      wr_prev_q <= io_wr;
      rd_prev_q <= io_rd;
      rd_data_q <= rd_data_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= cpu_dout;
  end

endmodule
